// File: rtl/pc_fetch_controller.sv
// PC fetch controller: boot sequencing, redirect priority and
// fetch-valid tracking for the instruction fetch front end.
module pc_fetch_controller #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int unsigned BOOT_CYCLES  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    input  logic        jump_i,
    input  logic [31:0] jump_target_i,
    input  logic        trap_i,
    input  logic        halt_i,
    input  logic        resume_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_next_o,
    output logic        pc_we_o,
    output logic        fetch_valid_o,
    output logic        flush_o,
    output logic        misaligned_o,
    output logic [2:0]  state_o,
    output logic [31:0] fetch_count_o
);

    typedef enum logic [2:0] {
        ST_BOOT  = 3'd0,
        ST_RUN   = 3'd1,
        ST_STALL = 3'd2,
        ST_FLUSH = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

    localparam logic [3:0] LP_BOOT_LAST = 4'(BOOT_CYCLES - 1);

    state_t      r_state;
    logic [31:0] r_pc;
    logic [3:0]  r_boot_cnt;
    logic        r_fv;
    logic        r_flush;
    logic        r_mis;
    logic [31:0] r_fetch_cnt;

    state_t      w_state_next;
    logic [31:0] w_pc_next;
    logic [3:0]  w_boot_next;
    logic        w_flush_next;
    logic        w_mis_next;
    logic        w_redir;
    logic [31:0] w_redir_tgt;

    assign w_redir     = jump_i | branch_taken_i;
    assign w_redir_tgt = jump_i ? jump_target_i : branch_target_i;

    // Next-state and next-PC selection; reset wins over everything
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_boot_next  = r_boot_cnt;
        w_flush_next = 1'b0;
        w_mis_next   = 1'b0;
        case (r_state)
            ST_BOOT: begin
                w_pc_next = RESET_VECTOR;
                if (r_boot_cnt == LP_BOOT_LAST) begin
                    w_state_next = ST_RUN;
                    w_boot_next  = 4'd0;
                end else begin
                    w_boot_next = r_boot_cnt + 4'd1;
                end
            end
            ST_RUN, ST_STALL: begin
                if (trap_i) begin
                    w_pc_next    = TRAP_VECTOR;
                    w_state_next = ST_FLUSH;
                    w_flush_next = 1'b1;
                end else if (w_redir) begin
                    w_state_next = ST_FLUSH;
                    w_flush_next = 1'b1;
                    if (w_redir_tgt[1:0] != 2'b00) begin
                        w_pc_next  = TRAP_VECTOR;
                        w_mis_next = 1'b1;
                    end else begin
                        w_pc_next = w_redir_tgt;
                    end
                end else if (halt_i) begin
                    w_state_next = ST_HALT;
                end else if (stall_i) begin
                    w_state_next = ST_STALL;
                end else if (r_state == ST_RUN) begin
                    w_pc_next = r_pc + 32'd4;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (trap_i) begin
                    w_pc_next    = TRAP_VECTOR;
                    w_flush_next = 1'b1;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            ST_HALT: begin
                if (trap_i) begin
                    w_pc_next    = TRAP_VECTOR;
                    w_state_next = ST_FLUSH;
                    w_flush_next = 1'b1;
                end else if (resume_i) begin
                    w_state_next = ST_RUN;
                end
            end
            default: begin
                w_state_next = ST_BOOT;
                w_pc_next    = RESET_VECTOR;
                w_boot_next  = 4'd0;
            end
        endcase
        if (!reset) begin
            w_state_next = ST_BOOT;
            w_pc_next    = RESET_VECTOR;
            w_boot_next  = 4'd0;
            w_flush_next = 1'b0;
            w_mis_next   = 1'b0;
        end
    end

    // State, PC and registered status outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_BOOT;
            r_pc        <= RESET_VECTOR;
            r_boot_cnt  <= 4'd0;
            r_fv        <= 1'b0;
            r_flush     <= 1'b0;
            r_mis       <= 1'b0;
            r_fetch_cnt <= 32'd0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_boot_cnt <= w_boot_next;
            r_fv       <= (w_state_next == ST_RUN);
            r_flush    <= w_flush_next;
            r_mis      <= w_mis_next;
            if (r_fv) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
        end
    end

    assign pc_o          = r_pc;
    assign pc_next_o     = w_pc_next;
    assign pc_we_o       = (w_pc_next != r_pc);
    assign fetch_valid_o = r_fv;
    assign flush_o       = r_flush;
    assign misaligned_o  = r_mis;
    assign state_o       = r_state;
    assign fetch_count_o = r_fetch_cnt;

endmodule

// File: tb/tb_pc_fetch_controller.sv
// Directed bench for pc_fetch_controller: expected post-edge values
// are queued when inputs are driven and checked after the edge.
module tb_pc_fetch_controller;

    localparam logic [2:0] B = 3'd0;
    localparam logic [2:0] R = 3'd1;
    localparam logic [2:0] S = 3'd2;
    localparam logic [2:0] F = 3'd3;
    localparam logic [2:0] H = 3'd4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall_i = 1'b0;
    logic        branch_taken_i = 1'b0;
    logic [31:0] branch_target_i = 32'd0;
    logic        jump_i = 1'b0;
    logic [31:0] jump_target_i = 32'd0;
    logic        trap_i = 1'b0;
    logic        halt_i = 1'b0;
    logic        resume_i = 1'b0;
    logic [31:0] pc_o;
    logic [31:0] pc_next_o;
    logic        pc_we_o;
    logic        fetch_valid_o;
    logic        flush_o;
    logic        misaligned_o;
    logic [2:0]  state_o;
    logic [31:0] fetch_count_o;

    pc_fetch_controller dut (
        .clk             (clk),
        .reset           (reset),
        .stall_i         (stall_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .jump_i          (jump_i),
        .jump_target_i   (jump_target_i),
        .trap_i          (trap_i),
        .halt_i          (halt_i),
        .resume_i        (resume_i),
        .pc_o            (pc_o),
        .pc_next_o       (pc_next_o),
        .pc_we_o         (pc_we_o),
        .fetch_valid_o   (fetch_valid_o),
        .flush_o         (flush_o),
        .misaligned_o    (misaligned_o),
        .state_o         (state_o),
        .fetch_count_o   (fetch_count_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [2:0]  st;
        logic        fv;
        logic        fl;
        logic        mi;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] m_cnt = 32'd0;
    logic [2:0]  m_st = B;
    logic [31:0] m_pc = 32'd0;
    bit          m_pv = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        stall_i = 1'b0;
        branch_taken_i = 1'b0;
        branch_target_i = 32'd0;
        jump_i = 1'b0;
        jump_target_i = 32'd0;
        trap_i = 1'b0;
        halt_i = 1'b0;
        resume_i = 1'b0;
    endtask

    // Called at the falling edge after inputs are driven
    task automatic cyc(input logic [31:0] pc, input logic [2:0] st,
                       input logic fv, input logic fl, input logic mi);
        exp_t e;
        #1;
        if (!reset) m_cnt = 32'd0;
        else if (m_st == R) m_cnt = m_cnt + 32'd1;
        e.pc = pc;
        e.st = st;
        e.fv = fv;
        e.fl = fl;
        e.mi = mi;
        e.cnt = m_cnt;
        chk("pc_next", pc_next_o, pc);
        if (m_pv) chk("pc_we", {31'd0, pc_we_o}, {31'd0, pc != m_pc});
        sb.push_back(e);
        m_st = st;
        m_pc = pc;
        m_pv = 1'b1;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("pc", pc_o, e.pc);
        chk("state", {29'd0, state_o}, {29'd0, e.st});
        chk("fetch_valid", {31'd0, fetch_valid_o}, {31'd0, e.fv});
        chk("flush", {31'd0, flush_o}, {31'd0, e.fl});
        chk("misaligned", {31'd0, misaligned_o}, {31'd0, e.mi});
        chk("fetch_count", fetch_count_o, e.cnt);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        idle();
        reset = 1'b0;
        @(negedge clk);
        // reset held for three cycles
        for (int i = 0; i < 3; i++) cyc(32'h0, B, 0, 0, 0);
        reset = 1'b1;
        // boot, then sequential fetch
        cyc(32'h0, B, 0, 0, 0);
        cyc(32'h0, R, 1, 0, 0);
        cyc(32'h4, R, 1, 0, 0);
        cyc(32'h8, R, 1, 0, 0);
        // jump beats branch
        jump_i = 1'b1; jump_target_i = 32'h40;
        branch_taken_i = 1'b1; branch_target_i = 32'h80;
        cyc(32'h40, F, 0, 1, 0);
        idle();
        cyc(32'h40, R, 1, 0, 0);
        cyc(32'h44, R, 1, 0, 0);
        // misaligned branch target
        branch_taken_i = 1'b1; branch_target_i = 32'h42;
        cyc(32'h100, F, 0, 1, 1);
        idle();
        cyc(32'h100, R, 1, 0, 0);
        cyc(32'h104, R, 1, 0, 0);
        // stall at 0x10
        jump_i = 1'b1; jump_target_i = 32'h10;
        cyc(32'h10, F, 0, 1, 0);
        idle();
        cyc(32'h10, R, 1, 0, 0);
        stall_i = 1'b1;
        cyc(32'h10, S, 0, 0, 0);
        cyc(32'h10, S, 0, 0, 0);
        cyc(32'h10, S, 0, 0, 0);
        stall_i = 1'b0;
        cyc(32'h10, R, 1, 0, 0);
        cyc(32'h14, R, 1, 0, 0);
        // trap beats jump; trap honoured in FLUSH, jump ignored there
        trap_i = 1'b1; jump_i = 1'b1; jump_target_i = 32'h40;
        cyc(32'h100, F, 0, 1, 0);
        jump_i = 1'b0;
        cyc(32'h100, F, 0, 1, 0);
        idle();
        jump_i = 1'b1; jump_target_i = 32'h200;
        cyc(32'h100, R, 1, 0, 0);
        // wrap at top of address space
        jump_i = 1'b1; jump_target_i = 32'hFFFF_FFFC;
        cyc(32'hFFFF_FFFC, F, 0, 1, 0);
        idle();
        cyc(32'hFFFF_FFFC, R, 1, 0, 0);
        cyc(32'h0, R, 1, 0, 0);
        cyc(32'h4, R, 1, 0, 0);
        // halt, ignored inputs, trap from halt, reset during flush
        halt_i = 1'b1;
        cyc(32'h4, H, 0, 0, 0);
        idle();
        stall_i = 1'b1; jump_i = 1'b1; jump_target_i = 32'h80;
        cyc(32'h4, H, 0, 0, 0);
        idle();
        trap_i = 1'b1;
        cyc(32'h100, F, 0, 1, 0);
        idle();
        reset = 1'b0;
        trap_i = 1'b1;
        cyc(32'h0, B, 0, 0, 0);
        idle();
        reset = 1'b1;
        cyc(32'h0, B, 0, 0, 0);
        cyc(32'h0, R, 1, 0, 0);
        // halt beats stall; resume holds pc
        halt_i = 1'b1; stall_i = 1'b1;
        cyc(32'h0, H, 0, 0, 0);
        idle();
        resume_i = 1'b1;
        cyc(32'h0, R, 1, 0, 0);
        idle();
        cyc(32'h4, R, 1, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
